filter_channel_scheduler: RTL and testbench

FILTER_CHANNEL_SCHEDULER -- requirements
Module: filter_channel_scheduler

---
 rtl/filter_channel_scheduler_pkg.sv | 22 ++
 rtl/filter_channel_scheduler_rr_picker.sv | 29 ++
 rtl/filter_channel_scheduler.sv | 138 +++++++++++++
 tb/tb_filter_channel_scheduler.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/filter_channel_scheduler_pkg.sv
// Shared types and defaults for the multi-channel chunk scheduler.
// Holds the FSM state encoding plus default timing constants.
package filter_channel_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_START = 2'd2,
    ST_BUSY  = 2'd3
  } state_t;

  localparam int DEF_START_DELAY = 64;
  localparam int DEF_TIMEOUT     = 4096;

  // One counter serves both DELAY and BUSY, so size it for the larger span.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/filter_channel_scheduler_rr_picker.sv
// Rotating-priority select: first set request at or after ptr, wrapping.
// Purely combinational; the caller owns the pointer register.
module filter_channel_scheduler_rr_picker #(
  parameter int NUM_CH  = 2,
  parameter int CH_BITS = 1
) (
  input  logic [NUM_CH-1:0]  i_req,
  input  logic [CH_BITS-1:0] i_ptr,
  output logic               o_vld,
  output logic [CH_BITS-1:0] o_idx
);

  logic [CH_BITS-1:0] w_cand;

  // Walk offsets from farthest to nearest so the nearest hit is assigned last.
  always_comb begin
    o_vld  = 1'b0;
    o_idx  = '0;
    w_cand = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      w_cand = CH_BITS'((int'(i_ptr) + k) % NUM_CH);
      if (i_req[w_cand]) begin
        o_vld = 1'b1;
        o_idx = w_cand;
      end
    end
  end

endmodule

// File: rtl/filter_channel_scheduler.sv
// Time-shares one chunk processor among NUM_CH audio channels: latches
// requests, grants round-robin, waits a settle delay, launches and watches it.
module filter_channel_scheduler
  import filter_channel_scheduler_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int CH_BITS     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int START_DELAY = DEF_START_DELAY,
  parameter int TIMEOUT     = DEF_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_CH-1:0]  chunk_pulse,
  input  logic               proc_done,
  input  logic               clear_err,
  output logic               proc_start,
  output logic [CH_BITS-1:0] chan_sel,
  output logic               active,
  output logic [NUM_CH-1:0]  pending,
  output logic [NUM_CH-1:0]  overrun,
  output logic               timeout_err
);

  localparam int CNT_W = cnt_width(START_DELAY, TIMEOUT);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [CH_BITS-1:0] r_chan;
  logic [CH_BITS-1:0] r_rr_ptr;
  logic               r_proc_start;
  logic               r_active;
  logic               r_timeout_err;
  logic [NUM_CH-1:0]  r_pending;
  logic [NUM_CH-1:0]  r_overrun;

  logic               w_pick_vld;
  logic [CH_BITS-1:0] w_pick_idx;
  logic               w_grant;
  logic [NUM_CH-1:0]  w_grant_vec;

  filter_channel_scheduler_rr_picker #(
    .NUM_CH  (NUM_CH),
    .CH_BITS (CH_BITS)
  ) u_rr_picker (
    .i_req (r_pending),
    .i_ptr (r_rr_ptr),
    .o_vld (w_pick_vld),
    .o_idx (w_pick_idx)
  );

  assign w_grant = (r_state == ST_IDLE) && w_pick_vld;

  always_comb begin
    w_grant_vec = '0;
    for (int i = 0; i < NUM_CH; i++)
      w_grant_vec[i] = w_grant && (w_pick_idx == CH_BITS'(i));
  end

  // A pulse landing on the grant cycle of its own channel re-arms pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= '0;
      r_overrun <= '0;
    end else begin
      r_pending <= (r_pending & ~w_grant_vec) | chunk_pulse;
      r_overrun <= (clear_err ? '0 : r_overrun)
                 | (chunk_pulse & r_pending & ~w_grant_vec);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_chan        <= '0;
      r_rr_ptr      <= '0;
      r_proc_start  <= 1'b0;
      r_active      <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_proc_start <= 1'b0;
      if (clear_err)
        r_timeout_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_pick_vld) begin
            r_chan   <= w_pick_idx;
            r_rr_ptr <= (w_pick_idx == CH_BITS'(NUM_CH - 1)) ? '0 : w_pick_idx + 1'b1;
            r_cnt    <= '0;
            r_active <= 1'b1;
            r_state  <= ST_DELAY;
          end
        end
        ST_DELAY: begin
          if (r_cnt == CNT_W'(START_DELAY - 1)) begin
            r_cnt        <= '0;
            r_proc_start <= 1'b1;
            r_state      <= ST_START;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_START: begin
          r_cnt   <= '0;
          r_state <= ST_BUSY;
        end
        ST_BUSY: begin
          // A done on the final watchdog cycle still counts as success.
          if (proc_done) begin
            r_cnt    <= '0;
            r_active <= 1'b0;
            r_state  <= ST_IDLE;
          end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
            r_cnt         <= '0;
            r_active      <= 1'b0;
            r_timeout_err <= 1'b1;
            r_state       <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_cnt    <= '0;
          r_active <= 1'b0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign proc_start  = r_proc_start;
  assign chan_sel    = r_chan;
  assign active      = r_active;
  assign pending     = r_pending;
  assign overrun     = r_overrun;
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_filter_channel_scheduler.sv
// Directed bench for filter_channel_scheduler with NUM_CH=2, START_DELAY=4,
// TIMEOUT=16; expected values are hand-derived cycle by cycle.
module tb_filter_channel_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] chunk_pulse;
  logic       proc_done;
  logic       clear_err;
  logic       proc_start;
  logic [0:0] chan_sel;
  logic       active;
  logic [1:0] pending;
  logic [1:0] overrun;
  logic       timeout_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  filter_channel_scheduler #(
    .NUM_CH      (2),
    .CH_BITS     (1),
    .START_DELAY (4),
    .TIMEOUT     (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .chunk_pulse (chunk_pulse),
    .proc_done   (proc_done),
    .clear_err   (clear_err),
    .proc_start  (proc_start),
    .chan_sel    (chan_sel),
    .active      (active),
    .pending     (pending),
    .overrun     (overrun),
    .timeout_err (timeout_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // n ticks; proc_start must be low on all but the last.
  task automatic expect_start(input string tag, input int n);
    for (int i = 1; i <= n; i++) begin
      tick();
      chk(tag, {31'd0, proc_start}, {31'd0, (i == n)});
    end
  endtask

  // From START: one BUSY cycle, then proc_done returns to IDLE.
  task automatic finish_busy(input string tag);
    tick();
    chk({tag, "_busy"}, {31'd0, active}, 32'd1);
    chk({tag, "_nostart"}, {31'd0, proc_start}, 32'd0);
    proc_done = 1'b1;
    tick();
    proc_done = 1'b0;
    chk({tag, "_idle"}, {31'd0, active}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; chunk_pulse = '0; proc_done = 1'b0; clear_err = 1'b0;
    tick(); tick();
    chk("rst_start", {31'd0, proc_start}, 32'd0);
    chk("rst_sel", {31'd0, chan_sel}, 32'd0);
    chk("rst_act", {31'd0, active}, 32'd0);
    chk("rst_pend", {30'd0, pending}, 32'd0);
    chk("rst_ovr", {30'd0, overrun}, 32'd0);
    chk("rst_to", {31'd0, timeout_err}, 32'd0);
    rst = 1'b0;

    // A: isolated ch0 request, proc_start six cycles after the pulse
    chunk_pulse = 2'b01; tick(); chunk_pulse = '0;
    chk("A_pend", {30'd0, pending}, 32'd1);
    chk("A_act0", {31'd0, active}, 32'd0);
    expect_start("A_lat", 5);
    chk("A_sel", {31'd0, chan_sel}, 32'd0);
    chk("A_act", {31'd0, active}, 32'd1);
    chk("A_pclr", {30'd0, pending}, 32'd0);
    finish_busy("A");
    chk("A_to", {31'd0, timeout_err}, 32'd0);

    // B: simultaneous pair from rr_ptr=0, twice
    rst = 1'b1; tick(); rst = 1'b0;
    chk("B_rst_act", {31'd0, active}, 32'd0);
    chunk_pulse = 2'b11; tick(); chunk_pulse = '0;
    chk("B_pend", {30'd0, pending}, 32'd3);
    expect_start("B_s0", 5);
    chk("B_sel0", {31'd0, chan_sel}, 32'd0);
    chk("B_pend1", {30'd0, pending}, 32'd2);
    finish_busy("B0");
    chk("B_wait1", {30'd0, pending}, 32'd2);
    tick();
    chk("B_g1_act", {31'd0, active}, 32'd1);
    chk("B_g1_sel", {31'd0, chan_sel}, 32'd1);
    chk("B_g1_pend", {30'd0, pending}, 32'd0);
    expect_start("B_s1", 4);
    finish_busy("B1");
    chunk_pulse = 2'b11; tick(); chunk_pulse = '0;
    expect_start("B_s2", 5);
    chk("B_sel2", {31'd0, chan_sel}, 32'd0);
    finish_busy("B2");
    tick();
    chk("B_sel3", {31'd0, chan_sel}, 32'd1);
    expect_start("B_s3", 4);
    finish_busy("B3");

    // C: ch0 pulsed twice while ch1 is busy
    chunk_pulse = 2'b10; tick(); chunk_pulse = '0;
    expect_start("C_s1", 5);
    chk("C_sel1", {31'd0, chan_sel}, 32'd1);
    tick();
    chunk_pulse = 2'b01; tick(); chunk_pulse = '0;
    chk("C_pend", {30'd0, pending}, 32'd1);
    chk("C_ovr0", {30'd0, overrun}, 32'd0);
    tick();
    chunk_pulse = 2'b01; tick(); chunk_pulse = '0;
    chk("C_ovr1", {30'd0, overrun}, 32'd1);
    clear_err = 1'b1; tick(); clear_err = 1'b0;
    chk("C_clr", {30'd0, overrun}, 32'd0);
    chunk_pulse = 2'b01; clear_err = 1'b1; tick(); chunk_pulse = '0; clear_err = 1'b0;
    chk("C_setwins", {30'd0, overrun}, 32'd1);
    clear_err = 1'b1; tick(); clear_err = 1'b0;
    chk("C_clr2", {30'd0, overrun}, 32'd0);
    chk("C_pend2", {30'd0, pending}, 32'd1);
    proc_done = 1'b1; tick(); proc_done = 1'b0;
    chk("C_idle", {31'd0, active}, 32'd0);
    tick();
    chk("C_sel0", {31'd0, chan_sel}, 32'd0);
    expect_start("C_s0", 4);
    finish_busy("C0");
    chk("C_once", {30'd0, pending}, 32'd0);

    // D: watchdog expiry with ch0 queued behind ch1
    chunk_pulse = 2'b10; tick(); chunk_pulse = '0;
    expect_start("D_s1", 5);
    chk("D_sel1", {31'd0, chan_sel}, 32'd1);
    for (int i = 1; i <= 16; i++) begin
      tick();
      chunk_pulse = (i == 1) ? 2'b01 : 2'b00;
      chk("D_busy", {31'd0, active}, 32'd1);
      chk("D_noto", {31'd0, timeout_err}, 32'd0);
    end
    tick();
    chk("D_idle", {31'd0, active}, 32'd0);
    chk("D_to", {31'd0, timeout_err}, 32'd1);
    chk("D_pend", {30'd0, pending}, 32'd1);
    tick();
    chk("D_next_act", {31'd0, active}, 32'd1);
    chk("D_next_sel", {31'd0, chan_sel}, 32'd0);
    expect_start("D_s0", 4);
    finish_busy("D0");
    chk("D_sticky", {31'd0, timeout_err}, 32'd1);
    clear_err = 1'b1; tick(); clear_err = 1'b0;
    chk("D_clr", {31'd0, timeout_err}, 32'd0);

    // D2: proc_done on the last watchdog cycle is a success
    chunk_pulse = 2'b10; tick(); chunk_pulse = '0;
    expect_start("D2_s", 5);
    for (int i = 1; i <= 16; i++) tick();
    chk("D2_busy", {31'd0, active}, 32'd1);
    proc_done = 1'b1; tick(); proc_done = 1'b0;
    chk("D2_idle", {31'd0, active}, 32'd0);
    chk("D2_noto", {31'd0, timeout_err}, 32'd0);

    // E: proc_done in IDLE and DELAY is ignored
    proc_done = 1'b1; tick(); proc_done = 1'b0;
    chk("E_idle_act", {31'd0, active}, 32'd0);
    chk("E_idle_to", {31'd0, timeout_err}, 32'd0);
    chunk_pulse = 2'b01; tick(); chunk_pulse = '0;
    tick();
    proc_done = 1'b1; tick(); proc_done = 1'b0;
    chk("E_dly_act", {31'd0, active}, 32'd1);
    chk("E_dly_start", {31'd0, proc_start}, 32'd0);
    expect_start("E_s", 3);
    finish_busy("E");
    chk("E_to", {31'd0, timeout_err}, 32'd0);

    // F: reset during DELAY; pulse during reset is dropped
    chunk_pulse = 2'b10; tick(); chunk_pulse = '0;
    tick();
    chk("F_dly_sel", {31'd0, chan_sel}, 32'd1);
    tick();
    rst = 1'b1; chunk_pulse = 2'b01; tick(); rst = 1'b0; chunk_pulse = '0;
    chk("F_act", {31'd0, active}, 32'd0);
    chk("F_pend", {30'd0, pending}, 32'd0);
    chk("F_sel", {31'd0, chan_sel}, 32'd0);
    chk("F_start", {31'd0, proc_start}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("F_quiet_start", {31'd0, proc_start}, 32'd0);
      chk("F_quiet_act", {31'd0, active}, 32'd0);
    end
    chunk_pulse = 2'b10; tick(); chunk_pulse = '0;
    expect_start("F_s", 5);
    chk("F_sel1", {31'd0, chan_sel}, 32'd1);
    finish_busy("F");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
